// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_REQ     = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    localparam int UART_DATA_W = 8;
    localparam int N_REQ_MAX   = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: returns the first set request at or
// after ptr, wrapping from N_REQ-1 back to 0.
module rr_pick
    import uart_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [ID_W-1:0]    w_off;
    logic [ID_W:0]      w_sum;

    // Rotate requests so ptr lands on bit 0, find the nearest set bit, map back.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_dbl = '0;
        w_rot = '0;
        w_off = '0;
        w_sum = '0;
        valid = 1'b0;
        idx   = '0;

        w_dbl = {req, req} >> ptr;
        w_rot = w_dbl[N_REQ-1:0];
        valid = |w_rot;

        // Descending scan so the lowest offset (nearest to ptr) wins.
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = ID_W'(j);
            end
        end

        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= (ID_W+1)'(N_REQ)) begin
            w_sum = w_sum - (ID_W+1)'(N_REQ);
        end
        idx = w_sum[ID_W-1:0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// Handshake with the transmitter: level tx_req, level tx_req_ack.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [N_REQ-1:0]             req,
    input  logic [UART_DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]             req_done,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy,
    output logic [UART_DATA_W-1:0]       tx_data,
    output logic                         tx_req,
    input  logic                         tx_req_ack
);

    arb_state_t             r_state;
    logic [ID_W-1:0]        r_ptr;
    logic [ID_W-1:0]        r_grant_id;
    logic [UART_DATA_W-1:0] r_tx_data;
    logic                   r_tx_req;
    logic                   r_busy;
    logic [N_REQ-1:0]       r_req_done;

    logic                   w_valid;
    logic [ID_W-1:0]        w_idx;
    logic [UART_DATA_W-1:0] w_bytes [N_REQ];

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_valid),
        .idx   (w_idx)
    );

    // Split the flat request data bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_bytes[i] = req_data[i*UART_DATA_W +: UART_DATA_W];
        end
    end

    // Arbitration FSM with all outputs registered; en low aborts to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_tx_data  <= '0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_req_done <= '0;
        end else if (!en) begin
            // Abort: byte is not reported done; tx_data, grant_id and ptr hold.
            r_state    <= ARB_IDLE;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_req_done <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            r_req_done <= '0;
            case (r_state)
                ARB_IDLE: begin
                    // A stale tx_req_ack here is ignored; only req drives a grant.
                    if (w_valid) begin
                        r_grant_id <= w_idx;
                        r_tx_data  <= w_bytes[w_idx];
                        r_tx_req   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (tx_req_ack) begin
                        r_tx_req   <= 1'b0;
                        r_req_done <= N_REQ'(1) << r_grant_id;
                        r_ptr      <= (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
                        r_state    <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    if (!tx_req_ack) begin
                        r_busy  <= 1'b0;
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    r_tx_req <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ARB_IDLE;
                end
            endcase
        end
    end

    assign req_done = r_req_done;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign tx_data  = r_tx_data;
    assign tx_req   = r_tx_req;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple level-handshake transmitter model.
module tb_uart_tx_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [N_REQ-1:0]  req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]  req_done;
    logic [ID_W-1:0]   grant_id;
    logic              busy;
    logic [7:0]        tx_data;
    logic              tx_req;
    logic              tx_req_ack = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    // Transmitter model controls
    logic       resp_on   = 1'b1;
    logic       ack_force = 1'b0;
    int         ack_dly   = 4;
    int         resp_cnt  = 0;
    logic [7:0] sent_q [$];
    int         sent_base = 0;

    // Requester model state
    logic [N_REQ-1:0] auto_drop    = '0;
    logic [N_REQ-1:0] reraise_mask = '0;
    logic [N_REQ-1:0] pending      = '0;
    int               done_q [$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ (N_REQ)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .req        (req),
        .req_data   (req_data),
        .req_done   (req_done),
        .grant_id   (grant_id),
        .busy       (busy),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .tx_req_ack (tx_req_ack)
    );

    // Transmitter model: raise ack ack_dly cycles after tx_req, drop it once tx_req falls.
    always @(negedge clk) begin
        if (!resp_on) begin
            tx_req_ack = ack_force;
            resp_cnt   = 0;
        end else if (reset) begin
            tx_req_ack = 1'b0;
            resp_cnt   = 0;
        end else if (tx_req && !tx_req_ack) begin
            resp_cnt++;
            if (resp_cnt >= ack_dly) begin
                tx_req_ack = 1'b1;
                sent_q.push_back(tx_data);
                resp_cnt = 0;
            end
        end else if (!tx_req) begin
            tx_req_ack = 1'b0;
            resp_cnt   = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Requester model, run once per cycle: log done pulses, drop/re-raise req.
    task automatic service();
        for (int i = 0; i < N_REQ; i++) begin
            if (pending[i]) begin
                pending[i] = 1'b0;
                if (reraise_mask[i]) req[i] = 1'b1;
            end
        end
        if (req_done != '0) begin
            check("done_onehot", $countones(req_done), 1);
            for (int i = 0; i < N_REQ; i++) begin
                if (req_done[i]) begin
                    done_q.push_back(i);
                    if (auto_drop[i]) begin
                        req[i]     = 1'b0;
                        pending[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        service();
    endtask

    task automatic clear_logs();
        done_q.delete();
        sent_base = sent_q.size();
    endtask

    task automatic wait_dones(input int n, input int budget, input string tag);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, done_q.size(), n);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while ((busy || tx_req) && k < budget) begin
            tick();
            k++;
        end
        check(tag, {30'b0, busy, tx_req}, 0);
    endtask

    task automatic wait_tx_req(input int budget, input string tag);
        int k = 0;
        while (!tx_req && k < budget) begin
            tick();
            k++;
        end
        check(tag, tx_req, 1);
    endtask

    task automatic do_reset();
        req = '0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pending = '0;
    endtask

    function automatic logic [7:0] sent_at(input int i);
        if (sent_base + i < sent_q.size()) return sent_q[sent_base + i];
        return 8'hxx;
    endfunction

    function automatic int done_at(input int i);
        if (i < done_q.size()) return done_q[i];
        return -1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_g [4];

        reset    = 1'b1;
        en       = 1'b1;
        req      = '0;
        req_data = '0;
        repeat (3) tick();

        // Reset values
        check("rst_tx_req",   tx_req,   0);
        check("rst_tx_data",  tx_data,  0);
        check("rst_req_done", req_done, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy",     busy,     0);
        reset = 1'b0;

        // 1. Single request: tx_req one cycle after req sampled
        tick();
        clear_logs();
        req_data[15:8] = 8'hA5;
        auto_drop      = 4'b0010;
        req            = 4'b0010;
        @(posedge clk);
        #1;
        check("t1_tx_req",   tx_req,   1);
        check("t1_busy",     busy,     1);
        check("t1_grant",    grant_id, 1);
        check("t1_tx_data",  tx_data,  8'hA5);
        check("t1_no_early", req_done, 0);
        wait_dones(1, 50, "t1_done_cnt");
        check("t1_done_id", done_at(0), 1);
        check("t1_sent",    sent_at(0), 8'hA5);
        wait_idle(20, "t1_idle");
        check("t1_one_done", done_q.size(), 1);

        // 2. Contention from ptr=0: order 0,1,2,3
        do_reset();
        clear_logs();
        req_data  = 32'h13121110;
        auto_drop = 4'b1111;
        req       = 4'b1111;
        wait_dones(4, 200, "t2_done_cnt");
        wait_idle(20, "t2_idle");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_grant%0d", i), done_at(i), i);
            check($sformatf("t2_byte%0d", i),  sent_at(i), 8'h10 + i);
        end

        // 4a. Last grant was 3 so ptr wrapped to 0: req 1001 -> 0 then 3
        tick();
        clear_logs();
        req_data  = 32'hD30000D0;
        auto_drop = 4'b1001;
        req       = 4'b1001;
        wait_dones(2, 100, "t4a_done_cnt");
        wait_idle(20, "t4a_idle");
        check("t4a_grant0", done_at(0), 0);
        check("t4a_grant1", done_at(1), 3);
        check("t4a_byte0",  sent_at(0), 8'hD0);
        check("t4a_byte1",  sent_at(1), 8'hD3);

        // 4b. Grant 2 leaves ptr=3: req 1001 -> 3 then 0
        tick();
        clear_logs();
        req_data  = 32'h00E20000;
        auto_drop = 4'b0100;
        req       = 4'b0100;
        wait_dones(1, 50, "t4b_pre_done");
        wait_idle(20, "t4b_pre_idle");
        tick();
        clear_logs();
        req_data  = 32'hF30000F0;
        auto_drop = 4'b1001;
        req       = 4'b1001;
        wait_dones(2, 100, "t4b_done_cnt");
        wait_idle(20, "t4b_idle");
        check("t4b_grant0", done_at(0), 3);
        check("t4b_grant1", done_at(1), 0);

        // 3. Fairness: req0 held, req2 re-requests after each done -> 0,2,0,2
        do_reset();
        clear_logs();
        req_data     = 32'h00B200B0;
        auto_drop    = 4'b0100;
        reraise_mask = 4'b0100;
        req          = 4'b0101;
        wait_dones(4, 400, "t3_done_cnt");
        reraise_mask = '0;
        auto_drop    = '0;
        req          = '0;
        wait_idle(40, "t3_idle");
        exp_g = '{0, 2, 0, 2};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_grant%0d", i), done_at(i), exp_g[i]);
            check($sformatf("t3_byte%0d", i),  sent_at(i), (exp_g[i] == 0) ? 8'hB0 : 8'hB2);
        end

        // 5. Abort with en low mid-transaction, then full retransmit
        tick();
        clear_logs();
        ack_dly        = 8;
        req_data       = '0;
        req_data[23:16] = 8'h5A;
        auto_drop      = 4'b0100;
        req            = 4'b0100;
        wait_tx_req(10, "t5_tx_req_up");
        repeat (3) tick();
        en = 1'b0;
        @(posedge clk);
        #1;
        check("t5_tx_req_low", tx_req,   0);
        check("t5_busy_low",   busy,     0);
        check("t5_no_done",    req_done, 0);
        check("t5_data_hold",  tx_data,  8'h5A);
        check("t5_grant_hold", grant_id, 2);
        repeat (3) tick();
        check("t5_no_done_log", done_q.size(), 0);
        check("t5_no_send",     sent_q.size() - sent_base, 0);
        en = 1'b1;
        wait_dones(1, 100, "t5_done_cnt");
        wait_idle(20, "t5_idle");
        check("t5_done_id", done_at(0), 2);
        check("t5_sent_cnt", sent_q.size() - sent_base, 1);
        check("t5_sent",     sent_at(0), 8'h5A);
        ack_dly = 4;

        // 6. Async reset in REQ, stale ack, ptr reset
        tick();
        clear_logs();
        req_data[7:0] = 8'hC3;
        auto_drop     = 4'b0001;
        req           = 4'b0001;
        wait_tx_req(10, "t6_tx_req_up");
        check("t6_data_pre", tx_data, 8'hC3);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_tx_req",   tx_req,   0);
        check("t6_rst_tx_data",  tx_data,  0);
        check("t6_rst_req_done", req_done, 0);
        check("t6_rst_grant",    grant_id, 0);
        check("t6_rst_busy",     busy,     0);
        req = '0;
        tick();
        reset   = 1'b0;
        pending = '0;
        resp_on   = 1'b0;
        ack_force = 1'b1;
        repeat (4) tick();
        check("t6_stale_busy",    busy,          0);
        check("t6_stale_tx_req",  tx_req,        0);
        check("t6_stale_no_done", done_q.size(), 0);
        ack_force = 1'b0;
        tick();
        resp_on = 1'b1;
        tick();
        clear_logs();
        req_data  = 32'h73007100;
        auto_drop = 4'b1010;
        req       = 4'b1010;
        wait_dones(2, 100, "t6_done_cnt");
        wait_idle(20, "t6_idle");
        check("t6_grant0", done_at(0), 1);
        check("t6_grant1", done_at(1), 3);
        check("t6_byte0",  sent_at(0), 8'h71);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
